// File: rtl/rx_bitproc.sv
// rx_bitproc: receive bit processor for a differential bit-serial bus.
// Decodes line states, NRZI-decodes J/K samples, hunts for SYNC, removes
// stuff bits, assembles bytes LSB first, and checks the EOP sequence.
// Optional feature macro: UTMI_RX_BABBLE_EN enables the per-packet byte
// limit MAX_PKT; without it packets of any length are accepted.
//
// state | meaning
// IDLE  | waiting for the first K with rx_en high
// SYNC  | shifting decoded bits, looking for SYNC_PAT within 16 bits
// DATA  | unstuffing and assembling bytes
// EOP   | one SE0 seen, expecting a second SE0 then J
// ERR   | rxerror raised, waiting for SE0 followed by J
module rx_bitproc #(
    parameter int         MAX_PKT  = 1027,
    parameter logic [7:0] SYNC_PAT = 8'h80
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dp,
    input  logic       dm,
    input  logic       rx_en,
    output logic [7:0] rxdata,
    output logic       rxvalid,
    output logic       rxactive,
    output logic       rxerror,
    output logic [1:0] linestate
);

    typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP, ERR} state_t;

    state_t     state, state_nxt;
    logic       prev_lvl, prev_nxt;
    logic [6:0] sync_win, sync_win_nxt;
    logic [3:0] sync_left, sync_left_nxt;
    logic [2:0] ones_left, ones_left_nxt;
    logic [2:0] bits_left, bits_left_nxt;
    logic [6:0] shreg, shreg_nxt;
    logic       se0_seen, se0_seen_nxt;
    logic [7:0] rxdata_nxt;
    logic       rxvalid_nxt, rxactive_nxt, rxerror_nxt;
    logic       line_j, line_k, se0, se1, bit_dec;
    logic [7:0] win_shift, byte_shift;

`ifdef UTMI_RX_BABBLE_EN
    localparam int BW = (MAX_PKT < 1) ? 1 : $clog2(MAX_PKT + 1);
    logic [BW-1:0] bytes_left, bytes_left_nxt;
`else
    logic unused_max_pkt;
    assign unused_max_pkt = ^MAX_PKT;
`endif

    assign linestate  = {dm, dp};
    assign line_j     = dp & ~dm;
    assign line_k     = ~dp & dm;
    assign se0        = ~dp & ~dm;
    assign se1        = dp & dm;
    // prev_lvl holds dp of the last J/K level, so equality means "no transition"
    assign bit_dec    = (dp == prev_lvl);
    assign win_shift  = {bit_dec, sync_win};
    assign byte_shift = {bit_dec, shreg};

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state, datapath updates and registered output values
    always_comb begin
        state_nxt     = state;
        prev_nxt      = prev_lvl;
        sync_win_nxt  = sync_win;
        sync_left_nxt = sync_left;
        ones_left_nxt = ones_left;
        bits_left_nxt = bits_left;
        shreg_nxt     = shreg;
        se0_seen_nxt  = se0_seen;
        rxdata_nxt    = rxdata;
        rxvalid_nxt   = 1'b0;
        rxactive_nxt  = rxactive;
        rxerror_nxt   = rxerror;
`ifdef UTMI_RX_BABBLE_EN
        bytes_left_nxt = bytes_left;
`endif
        if (!rx_en) begin
            state_nxt    = IDLE;
            rxactive_nxt = 1'b0;
            rxerror_nxt  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (line_k) begin
                        state_nxt     = SYNC;
                        prev_nxt      = 1'b0;
                        sync_win_nxt  = win_shift[7:1];
                        sync_left_nxt = 4'd15;
                    end
                end
                SYNC: begin
                    if (se0 || se1) begin
                        state_nxt = IDLE;
                    end else begin
                        prev_nxt     = dp;
                        sync_win_nxt = win_shift[7:1];
                        if (win_shift == SYNC_PAT) begin
                            state_nxt    = DATA;
                            rxactive_nxt = 1'b1;
                        end else if (sync_left == 4'd1) begin
                            state_nxt = IDLE;
                        end else begin
                            sync_left_nxt = sync_left - 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (se0) begin
                        state_nxt    = EOP;
                        se0_seen_nxt = 1'b0;
                    end else if (se1) begin
                        state_nxt   = ERR;
                        rxerror_nxt = 1'b1;
                    end else begin
                        prev_nxt = dp;
                        if (ones_left == 3'd0) begin
                            // bit after six 1s: a 0 is stuffing, a 1 is illegal
                            if (bit_dec) begin
                                state_nxt   = ERR;
                                rxerror_nxt = 1'b1;
                            end else begin
                                ones_left_nxt = 3'd6;
                            end
                        end
`ifdef UTMI_RX_BABBLE_EN
                        else if (bytes_left == '0) begin
                            state_nxt   = ERR;
                            rxerror_nxt = 1'b1;
                        end
`endif
                        else begin
                            ones_left_nxt = bit_dec ? ones_left - 3'd1 : 3'd6;
                            shreg_nxt     = byte_shift[7:1];
                            if (bits_left == 3'd0) begin
                                bits_left_nxt = 3'd7;
                                rxdata_nxt    = byte_shift;
                                rxvalid_nxt   = 1'b1;
`ifdef UTMI_RX_BABBLE_EN
                                bytes_left_nxt = bytes_left - 1'b1;
`endif
                            end else begin
                                bits_left_nxt = bits_left - 3'd1;
                            end
                        end
                    end
                end
                EOP: begin
                    if (!se0_seen) begin
                        if (se0) begin
                            se0_seen_nxt = 1'b1;
                        end else begin
                            state_nxt   = ERR;
                            rxerror_nxt = 1'b1;
                        end
                    end else if (line_j) begin
                        state_nxt    = IDLE;
                        rxactive_nxt = 1'b0;
                    end else if (!se0) begin
                        state_nxt    = ERR;
                        rxerror_nxt  = 1'b1;
                        se0_seen_nxt = 1'b0;
                    end
                end
                ERR: begin
                    if (se0) begin
                        se0_seen_nxt = 1'b1;
                    end else if (line_j && se0_seen) begin
                        state_nxt    = IDLE;
                        rxactive_nxt = 1'b0;
                        rxerror_nxt  = 1'b0;
                    end else begin
                        se0_seen_nxt = 1'b0;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
        // every path into IDLE restarts the decoder from a J reference
        if (state_nxt == IDLE) begin
            prev_nxt      = 1'b1;
            sync_win_nxt  = 7'h7F;
            sync_left_nxt = 4'd0;
            ones_left_nxt = 3'd6;
            bits_left_nxt = 3'd7;
            se0_seen_nxt  = 1'b0;
`ifdef UTMI_RX_BABBLE_EN
            bytes_left_nxt = BW'(MAX_PKT);
`endif
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_lvl  <= 1'b1;
            sync_win  <= 7'h7F;
            sync_left <= 4'd0;
            ones_left <= 3'd6;
            bits_left <= 3'd7;
            shreg     <= 7'h00;
            se0_seen  <= 1'b0;
            rxdata    <= 8'h00;
            rxvalid   <= 1'b0;
            rxactive  <= 1'b0;
            rxerror   <= 1'b0;
`ifdef UTMI_RX_BABBLE_EN
            bytes_left <= BW'(MAX_PKT);
`endif
        end else begin
            prev_lvl  <= prev_nxt;
            sync_win  <= sync_win_nxt;
            sync_left <= sync_left_nxt;
            ones_left <= ones_left_nxt;
            bits_left <= bits_left_nxt;
            shreg     <= shreg_nxt;
            se0_seen  <= se0_seen_nxt;
            rxdata    <= rxdata_nxt;
            rxvalid   <= rxvalid_nxt;
            rxactive  <= rxactive_nxt;
            rxerror   <= rxerror_nxt;
`ifdef UTMI_RX_BABBLE_EN
            bytes_left <= bytes_left_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_rx_bitproc.sv
// Testbench for rx_bitproc. A transmitter-side model builds line symbols
// from whole bytes (NRZI, bit stuffing, SYNC, EOP, injected faults) and
// records, per symbol, what rxvalid/rxdata/rxactive/rxerror must be after
// that symbol is sampled. Honors UTMI_RX_BABBLE_EN for the byte limit.
module tb_rx_bitproc;
    localparam int         MAXP      = 4;
    localparam logic [7:0] SYNC_BYTE = 8'h80;

    logic       clk, rst, dp, dm, rx_en;
    logic [7:0] rxdata;
    logic       rxvalid, rxactive, rxerror;
    logic [1:0] linestate;

    rx_bitproc #(.MAX_PKT(MAXP), .SYNC_PAT(SYNC_BYTE)) dut (
        .clk(clk), .rst(rst), .dp(dp), .dm(dm), .rx_en(rx_en),
        .rxdata(rxdata), .rxvalid(rxvalid), .rxactive(rxactive),
        .rxerror(rxerror), .linestate(linestate)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       sdp;
        logic       sdm;
        logic       sen;
        logic       ev;
        logic [7:0] ed;
        logic       ea;
        logic       ee;
    } step_t;

    step_t      steps[$];
    logic [7:0] cap[$];
    logic [7:0] exp_bytes[$];
    int         vectors = 0;
    int         miscompares = 0;

    // transmitter/model state
    logic lvl;
    int   ones;
    int   nbytes;
    logic m_act, m_err;
    logic saw_err;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, want, $time);
        end
    endtask

    function automatic logic babble_now();
`ifdef UTMI_RX_BABBLE_EN
        return nbytes == MAXP;
`else
        return 1'b0;
`endif
    endfunction

    task automatic m_reset();
        lvl = 1'b1; ones = 0; nbytes = 0; m_act = 1'b0; m_err = 1'b0;
    endtask

    task automatic push(input logic pdp, input logic pdm, input logic pen,
                        input logic pv, input logic [7:0] pd);
        step_t s;
        s.sdp = pdp; s.sdm = pdm; s.sen = pen; s.ev = pv; s.ed = pd;
        s.ea = m_act; s.ee = m_err;
        steps.push_back(s);
    endtask

    // NRZI: a 0 toggles the line level, a 1 keeps it
    task automatic send_level(input logic b, input logic pv, input logic [7:0] pd);
        if (!b) lvl = ~lvl;
        push(lvl, ~lvl, 1'b1, pv, pd);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) push(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    endtask

    task automatic sync();
        logic [7:0] sp;
        sp = SYNC_BYTE;
        for (int i = 0; i < 8; i++) begin
            if (i == 7) m_act = 1'b1;
            send_level(sp[i], 1'b0, 8'h00);
        end
        ones = 0; nbytes = 0;
    endtask

    // one data bit, stuffed after six 1s; pv marks the byte's last bit
    task automatic tx_bit(input logic b, input logic pv, input logic [7:0] pd);
        logic v;
        v = pv;
        if (!m_err && babble_now()) m_err = 1'b1;
        if (m_err) v = 1'b0;
        if (v) nbytes++;
        ones = b ? ones + 1 : 0;
        send_level(b, v, pd);
        if (ones == 6) begin
            ones = 0;
            send_level(1'b0, 1'b0, 8'h00);
        end
    endtask

    task automatic tx_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) tx_bit(v[i], i == 7, v);
    endtask

    task automatic tx_partial(input int n);
        for (int i = 0; i < n; i++) tx_bit(1'($urandom_range(0, 1)), 1'b0, 8'h00);
    endtask

    // raw 1s with no stuffing: the bit after six 1s is a stuff error
    task automatic seven_ones();
        for (int i = 0; i < 7; i++) begin
            if (!m_err) begin
                if (ones == 6) m_err = 1'b1;
                else if (babble_now()) m_err = 1'b1;
                else ones++;
            end
            send_level(1'b1, 1'b0, 8'h00);
        end
        ones = 0;
    endtask

    task automatic se1();
        m_err = 1'b1;
        push(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    endtask

    task automatic en_drop();
        m_act = 1'b0; m_err = 1'b0;
        push(lvl, ~lvl, 1'b0, 1'b0, 8'h00);
        lvl = 1'b1;
    endtask

    task automatic eop();
        push(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        push(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        m_act = 1'b0; m_err = 1'b0; lvl = 1'b1;
        push(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    endtask

    // 16 decoded zeros: SYNC must give up without raising anything
    task automatic sync_timeout();
        for (int i = 0; i < 16; i++) send_level(1'b0, 1'b0, 8'h00);
        lvl = 1'b1;
    endtask

    // drive queued symbols and compare every cycle
    task automatic run();
        step_t s;
        while (steps.size() > 0) begin
            s = steps.pop_front();
            @(negedge clk);
            dp = s.sdp; dm = s.sdm; rx_en = s.sen;
            @(posedge clk);
            #1;
            chk("rxvalid", 32'(rxvalid), 32'(s.ev));
            chk("rxactive", 32'(rxactive), 32'(s.ea));
            chk("rxerror", 32'(rxerror), 32'(s.ee));
            chk("linestate", 32'(linestate), 32'({s.sdm, s.sdp}));
            if (s.ev) chk("rxdata", 32'(rxdata), 32'(s.ed));
            if (rxvalid) cap.push_back(rxdata);
            if (rxerror) saw_err = 1'b1;
        end
    endtask

    task automatic check_bytes(input string nm);
        chk({nm, "_count"}, 32'(cap.size()), 32'(exp_bytes.size()));
        for (int i = 0; i < exp_bytes.size() && i < cap.size(); i++)
            chk(nm, 32'(cap[i]), 32'(exp_bytes[i]));
        cap.delete();
        saw_err = 1'b0;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_rxdata"}, 32'(rxdata), 32'h0);
        chk({nm, "_rxvalid"}, 32'(rxvalid), 32'h0);
        chk({nm, "_rxactive"}, 32'(rxactive), 32'h0);
        chk({nm, "_rxerror"}, 32'(rxerror), 32'h0);
    endtask

    initial begin
        int nb;
        int kind;
        rst = 1'b0; dp = 1'b1; dm = 1'b0; rx_en = 1'b1;
        saw_err = 1'b0;
        m_reset();
        #2;
        chk_zero("reset");
        chk("reset_linestate", 32'(linestate), 32'h1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        idle(3); sync(); tx_byte(8'hA5); eop(); idle(2); run();
        exp_bytes = '{8'hA5};
        chk("a5_err", 32'(saw_err), 32'h0);
        check_bytes("pkt_a5");

        sync(); tx_byte(8'hFF); tx_byte(8'h01); eop(); idle(2); run();
        exp_bytes = '{8'hFF, 8'h01};
        chk("stuff_ok_err", 32'(saw_err), 32'h0);
        check_bytes("pkt_ff01");

        sync(); tx_byte(8'h3C); seven_ones(); eop(); idle(2); run();
        exp_bytes = '{8'h3C};
        chk("stuff_err_seen", 32'(saw_err), 32'h1);
        check_bytes("pkt_stufferr");

        sync(); tx_partial(4); se1(); eop(); idle(2); run();
        exp_bytes = {};
        chk("se1_err_seen", 32'(saw_err), 32'h1);
        check_bytes("pkt_se1");

        sync(); tx_byte(8'h12); tx_partial(3); en_drop(); idle(3); run();
        exp_bytes = '{8'h12};
        chk("endrop_err", 32'(saw_err), 32'h0);
        check_bytes("pkt_endrop");

        sync_timeout(); idle(3); sync(); tx_byte(8'h5A); eop(); idle(2); run();
        exp_bytes = '{8'h5A};
        check_bytes("pkt_timeout");

        sync(); tx_byte(8'h11); tx_byte(8'h22); tx_byte(8'h33);
        tx_byte(8'h44); tx_byte(8'h55); eop(); idle(2); run();
`ifdef UTMI_RX_BABBLE_EN
        exp_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
        chk("babble_err", 32'(saw_err), 32'h1);
`else
        exp_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        chk("babble_err", 32'(saw_err), 32'h0);
`endif
        check_bytes("pkt_babble");

        for (int p = 0; p < 40; p++) begin
            idle($urandom_range(1, 4));
            sync();
            nb = $urandom_range(0, 5);
            for (int b = 0; b < nb; b++)
                tx_byte(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom));
            kind = $urandom_range(0, 9);
            case (kind)
                0: begin tx_partial($urandom_range(1, 7)); se1(); eop(); end
                1: begin seven_ones(); eop(); end
                2: begin tx_partial($urandom_range(0, 7)); en_drop(); end
                3: begin tx_partial($urandom_range(1, 7)); eop(); end
                default: eop();
            endcase
            run();
        end
        cap.delete();
        saw_err = 1'b0;

        idle(2); sync(); tx_byte(8'hC3); tx_byte(8'h7E); tx_byte(8'h99); run();
        cap.delete();
        @(negedge clk);
        #2;
        dp = 1'b1; dm = 1'b0;
        rst = 1'b0;
        #1;
        chk_zero("midreset");
        repeat (2) @(negedge clk);
        chk_zero("midreset_hold");
        rst = 1'b1;
        m_reset();
        idle(3); sync(); tx_byte(8'h3C); eop(); idle(2); run();
        exp_bytes = '{8'h3C};
        chk("after_reset_err", 32'(saw_err), 32'h0);
        check_bytes("pkt_after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
